// File: rtl/ls_mem_ctrl_pkg.sv
// Shared defines, types and helpers for the LS memory controller.
// The optional stack scratchpad is enabled with LS_STACK_EN (see ls_mem_ctrl).
`ifndef LS_MEM_DEFS
`define LS_MEM_DEFS
`define WORD_T logic [31:0]
`define ADDR_T logic [31:0]
`define BYTE_T logic [7:0]
`define READ_SIGNAL 1'b0
`define WRITE_SIGNAL 1'b1
`ifndef STK
`define STK 12
`endif
`define NULL_PTR 32'h0000_0000
`endif

package ls_mem_ctrl_pkg;
  typedef `WORD_T word_t;
  typedef `ADDR_T addr_t;
  typedef `BYTE_T byte_t;

  localparam logic  OP_READ  = `READ_SIGNAL;
  localparam logic  OP_WRITE = `WRITE_SIGNAL;
  localparam int    STK_W    = `STK;
  localparam addr_t NULL_PTR = `NULL_PTR;

  // Queue entry carries the already-normalised byte count rather than the raw size.
  typedef struct packed {
    logic       oper;
    addr_t      addr;
    logic [2:0] n;
    word_t      data;
  } ls_req_t;

  typedef enum logic [1:0] {S_IDLE, S_RD, S_FIN, S_WR} ls_state_e;

  function automatic logic [2:0] req_bytes(input logic [2:0] sz);
    case (sz)
      3'd0, 3'd1: return 3'd1;
      3'd2:       return 3'd2;
      default:    return 3'd4;
    endcase
  endfunction
endpackage

// File: rtl/ls_req_fifo.sv
// Parameterised request FIFO: push/pop with occupancy count and registered head pointer.
module ls_req_fifo
  import ls_mem_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CW-1:0]    count_o,
  output logic             empty_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // Push while full is dropped; pop while empty is ignored.
  assign do_push = en_i & push_i & (cnt_q != CW'(DEPTH));
  assign do_pop  = en_i & pop_i & (cnt_q != '0);
  assign cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= inc(wr_q);
      if (do_pop)  rd_q <= inc(rd_q);
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;
  assign empty_o = (cnt_q == '0);
endmodule

// File: rtl/ls_mem_ctrl.sv
// LS memory-side responder: queued in-order byte-serial RAM access with read completion pulse.
// Define LS_STACK_EN to serve stack-region accesses from an unqueued internal scratchpad.
module ls_mem_ctrl
  import ls_mem_ctrl_pkg::*;
#(
  parameter int QUEUE_SIZE = 16,
  parameter int STK_BYTES  = 2**STK_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        en_ls,
  input  logic        ls_oper,
  input  logic [31:0] ls_addr,
  input  logic [7:0]  ls_size,
  input  logic [31:0] ls_data,
  output logic [31:0] qsize,
  output logic        finish,
  output logic [31:0] ls_data_out,
  output logic [31:0] stk_data_out,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr
);
  localparam int CW = $clog2(QUEUE_SIZE + 1);

  ls_state_e  state_q, state_d;
  addr_t      addr_q, addr_d;
  word_t      data_q, data_d, dout_q, dout_d;
  logic [2:0] n_q, n_d, k_q, k_d;
  logic       fin_q, fin_d;

  ls_req_t    push_req, head;
  logic [CW-1:0] count;
  logic       empty, push, pop, stack_hit;
  logic       unused_size;

  assign unused_size = ^ls_size[7:3];
  assign push_req    = '{oper: ls_oper, addr: ls_addr, n: req_bytes(ls_size[2:0]), data: ls_data};
  assign push        = en_ls & ~stack_hit;

  ls_req_fifo #(.WIDTH($bits(ls_req_t)), .DEPTH(QUEUE_SIZE)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .en_i    (rdy),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (push_req),
    .head_o  (head),
    .count_o (count),
    .empty_o (empty)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    data_d   = data_q;
    n_d      = n_q;
    k_d      = k_q;
    fin_d    = 1'b0;
    dout_d   = dout_q;
    pop      = 1'b0;
    mem_a    = NULL_PTR;
    mem_wr   = 1'b0;
    mem_dout = '0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          addr_d  = head.addr;
          n_d     = head.n;
          k_d     = '0;
          data_d  = (head.oper == OP_WRITE) ? head.data : '0;
          state_d = (head.oper == OP_WRITE) ? S_WR : S_RD;
        end
      end
      S_RD: begin
        // mem_din lags mem_a by one cycle, so capture starts at k=1 and ends at k=n.
        if (k_q < n_q) mem_a = addr_q + 32'(k_q);
        if (k_q != '0) data_d = {data_q[23:0], mem_din};
        if (k_q == n_q) begin
          state_d = S_FIN;
          fin_d   = 1'b1;
          dout_d  = {data_q[23:0], mem_din};
        end else begin
          k_d = k_q + 3'd1;
        end
      end
      S_FIN: state_d = S_IDLE;
      S_WR: begin
        mem_a    = addr_q + 32'(k_q);
        mem_wr   = 1'b1;
        mem_dout = data_q[{k_q[1:0], 3'b000} +: 8];
        if (k_q == n_q - 3'd1) state_d = S_IDLE;
        else                   k_d = k_q + 3'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      n_q     <= '0;
      k_q     <= '0;
      fin_q   <= 1'b0;
      dout_q  <= '0;
    end else if (rdy) begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      n_q     <= n_d;
      k_q     <= k_d;
      fin_q   <= fin_d;
      dout_q  <= dout_d;
    end
  end

  assign qsize       = 32'(count);
  assign finish      = fin_q;
  assign ls_data_out = dout_q;

`ifdef LS_STACK_EN
  localparam int SW = $clog2(STK_BYTES);

  logic [7:0]    stk_mem [STK_BYTES];
  logic [SW-1:0] stk_a_q;
  logic [2:0]    stk_n_q;

  assign stack_hit = &ls_addr[16:SW];

  // Scratchpad is deliberately not reset; indices wrap within the region.
  always_ff @(posedge clk) begin
    if (rdy && en_ls && stack_hit && ls_oper == OP_WRITE)
      for (int i = 0; i < 4; i++)
        if (3'(i) < push_req.n) stk_mem[ls_addr[SW-1:0] + SW'(i)] <= ls_data[8*i +: 8];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stk_a_q <= '0;
      stk_n_q <= 3'd1;
    end else if (rdy && en_ls && stack_hit && ls_oper == OP_READ) begin
      stk_a_q <= ls_addr[SW-1:0];
      stk_n_q <= push_req.n;
    end
  end

  always_comb begin
    stk_data_out = '0;
    for (int i = 0; i < 4; i++)
      if (3'(i) < stk_n_q) stk_data_out = {stk_data_out[23:0], stk_mem[stk_a_q + SW'(i)]};
  end
`else
  assign stack_hit    = 1'b0;
  assign stk_data_out = '0;
`endif
endmodule

// File: tb/tb_ls_mem_ctrl.sv
// Directed self-checking bench for ls_mem_ctrl with a registered byte-wide RAM model.
module tb_ls_mem_ctrl;
  localparam logic RD = 1'b0;
  localparam logic WR = 1'b1;

  logic        clk = 1'b0, rst = 1'b1, rdy = 1'b1, en_ls = 1'b0, ls_oper = 1'b0;
  logic [31:0] ls_addr = '0, ls_data = '0;
  logic [7:0]  ls_size = '0;
  logic [31:0] qsize, ls_data_out, stk_data_out, mem_a;
  logic [7:0]  mem_din, mem_dout;
  logic        finish, mem_wr;

  logic [7:0]  ram [4096];
  logic        tb_we = 1'b0;
  logic [11:0] tb_wa = '0;
  logic [7:0]  tb_wd = '0;

  int          n_chk = 0, n_fail = 0;
  int          cyc, n_wr, drop_hits;
  logic        mon_on = 1'b0;
  logic [31:0] exp_wa, swd;

  ls_mem_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy), .en_ls(en_ls), .ls_oper(ls_oper),
    .ls_addr(ls_addr), .ls_size(ls_size), .ls_data(ls_data),
    .qsize(qsize), .finish(finish), .ls_data_out(ls_data_out), .stk_data_out(stk_data_out),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (tb_we)       ram[tb_wa] <= tb_wd;
    else if (mem_wr) ram[mem_a[11:0]] <= mem_dout;
    mem_din <= ram[mem_a[11:0]];
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Store-order monitor for the 0x300 region, active only while mon_on is set.
  task automatic mon();
    if (mon_on && mem_wr && mem_a[31:8] == 24'h3) begin
      if (mem_a == 32'h380) drop_hits++;
      else if (mem_a[1:0] == 2'b00) begin
        chk("drain_order", mem_a, exp_wa);
        exp_wa += 32'd4;
        n_wr++;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    mon();
  endtask

  task automatic req(input logic op, input logic [31:0] a, input logic [7:0] sz, input logic [31:0] d);
    en_ls = 1'b1; ls_oper = op; ls_addr = a; ls_size = sz; ls_data = d;
  endtask

  task automatic wait_fin(input int budget, output int c);
    c = -1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (finish) begin c = i; break; end
    end
  endtask

  task automatic drain(input string tag, input int budget);
    int quiet, t;
    quiet = 0; t = 0;
    while (quiet < 3 && t < budget) begin
      tick(); t++;
      if (qsize == 0 && !mem_wr) quiet++; else quiet = 0;
    end
    chk(tag, 32'(quiet), 32'd3);
  endtask

  function automatic logic [31:0] ramw(input logic [11:0] a);
    return {ram[a + 12'd3], ram[a + 12'd2], ram[a + 12'd1], ram[a]};
  endfunction

  initial begin
    // Preload RAM[0x100..0x103] during reset
    for (int i = 0; i < 4; i++) begin
      tb_we = 1'b1; tb_wa = 12'h100 + 12'(i); tb_wd = 8'h11 * 8'(i + 1);
      @(posedge clk); #1;
    end
    tb_we = 1'b0;
    chk("rst_qsize", qsize, 32'd0);
    chk("rst_finish", 32'(finish), 32'd0);
    chk("rst_dout", ls_data_out, 32'd0);
    chk("rst_mem_a", mem_a, 32'd0);
    chk("rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("rst_mem_dout", 32'(mem_dout), 32'd0);
`ifndef LS_STACK_EN
    chk("rst_stk_out", stk_data_out, 32'd0);
`endif
    rst = 1'b0;
    tick(); tick();

    // LW 0x100
    req(RD, 32'h100, 8'd4, 32'h0); tick(); en_ls = 1'b0;
    chk("lw_q1", qsize, 32'd1);
    tick();
    chk("lw_pop_q", qsize, 32'd0);
    chk("lw_a0", mem_a, 32'h100);
    chk("lw_wr0", 32'(mem_wr), 32'd0);
    wait_fin(12, cyc);
    chk("lw_latency", 32'(cyc), 32'd5);
    chk("lw_data", ls_data_out, 32'h11223344);
    tick();
    chk("lw_pulse", 32'(finish), 32'd0);
    chk("lw_hold", ls_data_out, 32'h11223344);

    // Reset asserted mid-RD with a second load queued
    req(RD, 32'h100, 8'd4, 32'h0); tick();
    req(RD, 32'h104, 8'd4, 32'h0); tick(); en_ls = 1'b0;
    chk("rst_pre_q", qsize, 32'd1);
    tick();
    chk("rst_mid_a", mem_a, 32'h101);
    #2 rst = 1'b1;
    #1;
    chk("rstmid_q", qsize, 32'd0);
    chk("rstmid_wr", 32'(mem_wr), 32'd0);
    chk("rstmid_a", mem_a, 32'd0);
    chk("rstmid_fin", 32'(finish), 32'd0);
    chk("rstmid_dout", ls_data_out, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rstmid_fin_hold", 32'(finish), 32'd0);
    end
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("post_rst_fin", 32'(finish), 32'd0);
    end
    chk("post_rst_q", qsize, 32'd0);

    // SW 0x200
    swd = 32'hAABBCCDD;
    req(WR, 32'h200, 8'd4, swd); tick(); en_ls = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("sw_a", mem_a, 32'h200 + 32'(i));
      chk("sw_d", 32'(mem_dout), 32'(swd[8*i +: 8]));
      chk("sw_we", 32'(mem_wr), 32'd1);
      chk("sw_fin", 32'(finish), 32'd0);
      tick();
    end
    chk("sw_end_we", 32'(mem_wr), 32'd0);
    chk("sw_end_a", mem_a, 32'd0);
    chk("sw_end_fin", 32'(finish), 32'd0);

    // Fill to full with back-to-back word stores, then one dropped store
    mon_on = 1'b1; exp_wa = 32'h300; n_wr = 0; drop_hits = 0;
    for (int i = 0; i < 20; i++) begin
      req(WR, 32'h300 + 32'(4*i), 8'd4, 32'hC0DE0000 + 32'(i));
      tick();
    end
    chk("fill_q16", qsize, 32'd16);
    req(WR, 32'h380, 8'd4, 32'hEEEEEEEE); tick(); en_ls = 1'b0;
    chk("full_drop_q", qsize, 32'd16);
    drain("fill_drain", 200);
    chk("fill_nwr", 32'(n_wr), 32'd20);
    chk("fill_dropped", 32'(drop_hits), 32'd0);
    chk("fill_w0", ramw(12'h300), 32'hC0DE0000);
    chk("fill_w10", ramw(12'h328), 32'hC0DE000A);
    chk("fill_w19", ramw(12'h34C), 32'hC0DE0013);
    mon_on = 1'b0;

    // Push coincident with pop at qsize=3, then rdy stall mid-WR
    req(WR, 32'h400, 8'd4, 32'h03020100); tick();
    req(WR, 32'h404, 8'd4, 32'h17161514); tick();
    chk("ovl_a0", mem_a, 32'h400);
    req(WR, 32'h408, 8'd4, 32'h2B2A2928); tick();
    req(WR, 32'h40C, 8'd4, 32'h3F3E3D3C); tick(); en_ls = 1'b0;
    tick(); tick();
    chk("ovl_pre_q", qsize, 32'd3);
    chk("ovl_pre_we", 32'(mem_wr), 32'd0);
    req(WR, 32'h410, 8'd4, 32'h53525150); tick(); en_ls = 1'b0;
    chk("ovl_q3", qsize, 32'd3);
    chk("ovl_b0", mem_a, 32'h404);
    tick();
    chk("stall_pre_a", mem_a, 32'h405);
    chk("stall_pre_d", 32'(mem_dout), 32'h15);
    rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_a", mem_a, 32'h405);
      chk("stall_we", 32'(mem_wr), 32'd1);
      chk("stall_d", 32'(mem_dout), 32'h15);
      chk("stall_q", qsize, 32'd3);
    end
    rdy = 1'b1;
    tick();
    chk("resume_a2", mem_a, 32'h406);
    chk("resume_d2", 32'(mem_dout), 32'h16);
    tick();
    chk("resume_a3", mem_a, 32'h407);
    chk("resume_d3", 32'(mem_dout), 32'h17);
    tick();
    chk("resume_idle", 32'(mem_wr), 32'd0);
    drain("ovl_drain", 100);
    chk("ovl_wA", ramw(12'h400), 32'h03020100);
    chk("ovl_wB", ramw(12'h404), 32'h17161514);
    chk("ovl_wD", ramw(12'h40C), 32'h3F3E3D3C);
    chk("ovl_wE", ramw(12'h410), 32'h53525150);

    // Stack-region SB/LB
`ifdef LS_STACK_EN
    req(WR, 32'h1FFF0, 8'd1, 32'h5A); tick();
    chk("stk_sb_q", qsize, 32'd0);
    chk("stk_sb_we", 32'(mem_wr), 32'd0);
    req(RD, 32'h1FFF0, 8'd1, 32'h0); tick(); en_ls = 1'b0;
    chk("stk_lb_q", qsize, 32'd0);
    chk("stk_lb_d", stk_data_out, 32'h5A);
    req(WR, 32'h1FFF4, 8'd4, 32'h44332211); tick();
    req(RD, 32'h1FFF4, 8'd4, 32'h0); tick(); en_ls = 1'b0;
    chk("stk_lw_q", qsize, 32'd0);
    chk("stk_lw_d", stk_data_out, 32'h11223344);
    chk("stk_lw_fin", 32'(finish), 32'd0);
`else
    req(WR, 32'h1FFF0, 8'd1, 32'h5A); tick();
    chk("nostk_sb_q", qsize, 32'd1);
    req(RD, 32'h1FFF0, 8'd1, 32'h0); tick(); en_ls = 1'b0;
    chk("nostk_lb_q", qsize, 32'd1);
    chk("nostk_sb_a", mem_a, 32'h1FFF0);
    chk("nostk_sb_d", 32'(mem_dout), 32'h5A);
    wait_fin(12, cyc);
    chk("nostk_lb_lat", 32'(cyc), 32'd4);
    chk("nostk_lb_d", ls_data_out, 32'h5A);
    chk("nostk_stk_out", stk_data_out, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
